if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the instruction driven on instrF whenever validF=0.
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port StallF, input, 1 bit: hazard-unit hold; 1 keeps the current PC and instruction.
REQ-006 Port PCSrcE, input, 1 bit: taken branch or jump resolved in execute.
REQ-007 Port PCTargetE, input, 32 bits: redirect target, sampled when PCSrcE=1.
REQ-008 Port imem_req, output, 1 bit: instruction memory request.
REQ-009 Port imem_addr, output, 32 bits: request address, always equal to PCF.
REQ-010 Port imem_ready, input, 1 bit: memory accepts the request this cycle.
REQ-011 Port imem_rvalid, input, 1 bit: read data valid.
REQ-012 Port imem_rdata, input, 32 bits: returned instruction.
REQ-013 Port instrF, output, 32 bits: instruction sent to the IF/ID register.
REQ-014 Port PCF, output, 32 bits: current fetch PC.
REQ-015 Port PCplus4F, output, 32 bits: PCF+4.
REQ-016 Port validF, output, 1 bit: instrF holds a real instruction.
REQ-017 Port fetch_busy, output, 1 bit: equals ~validF; the hazard unit uses it to stall IF/ID.

Function
REQ-018 The FSM SHALL use states IDLE, REQ, WAIT and HAVE, with at most one request outstanding.
REQ-019 IDLE: imem_req=0; the FSM moves to REQ on the first clock edge after reset deassertion.
REQ-020 REQ: imem_req=1; on imem_ready=1 the FSM moves to WAIT, otherwise it stays in REQ.
REQ-021 WAIT: imem_req=0; on imem_rvalid=1 the FSM latches imem_rdata into the instruction buffer and moves to HAVE, unless the discard flag is set.
REQ-022 HAVE: validF=1 and instrF=buffer; if StallF=0, PC<=PC+4 and the FSM moves to REQ; if StallF=1, PC and buffer hold.
REQ-023 Redirect in IDLE/REQ/HAVE: when PCSrcE=1, PC<=PCTargetE and the FSM moves to REQ at the next edge; any buffered instruction is dropped.
REQ-024 Redirect in WAIT: when PCSrcE=1, PC<=PCTargetE and the discard flag is set; the next imem_rvalid is dropped, the flag clears, and the FSM moves to REQ.
REQ-025 PCSrcE SHALL take priority over StallF.
REQ-026 A redirect coincident with imem_rvalid in WAIT SHALL drop that response.
REQ-027 All PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 Latency SHALL be one cycle from REQ acceptance to WAIT; validF rises on the edge that captures rvalid.
REQ-029 Outside HAVE: validF=0 and instrF=NOP_INSTR.

Reset
REQ-030 While rst=0: state=IDLE, PC=RESET_PC, buffer=NOP_INSTR, discard=0, imem_req=0, validF=0, fetch_busy=1, instrF=NOP_INSTR, PCF=RESET_PC, PCplus4F=RESET_PC+4.
REQ-031 Reset asserted mid-request SHALL abandon the request; an rvalid arriving after reset, before a new request, SHALL be ignored.

Configuration
REQ-032 With macro FETCH_PERF_CNT_EN defined, outputs perf_fetch_cnt (32 bits, counts HAVE->REQ advances) and perf_discard_cnt (16 bits, counts dropped responses) SHALL exist; both saturate and reset to 0.
REQ-033 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-034 Reset release, imem_ready=1, rvalid one cycle later with 32'h00500093 -> imem_addr=0, then validF=1, instrF=32'h00500093, PCF=0, PCplus4F=4.
REQ-035 HAVE at PC=8 with StallF=1 for 3 cycles -> PCF=8 and instrF stable, imem_req=0; StallF=0 -> next request at address 12.
REQ-036 WAIT at PC=16, PCSrcE=1, PCTargetE=32'h40 -> stale response dropped, next imem_addr=32'h40, perf_discard_cnt=1 when FETCH_PERF_CNT_EN is defined.
REQ-037 PCSrcE=1 and StallF=1 in the same HAVE cycle -> PCF=PCTargetE at the next edge, validF=0.
REQ-038 PC=32'hFFFF_FFFC advancing -> PCF=0, PCplus4F=4; imem_ready held 0 for 5 cycles -> imem_req stays 1, validF=0, instrF=32'h00000013.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with a single-outstanding-request memory FSM (IDLE/REQ/WAIT/HAVE).
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        validF,
  output logic        fetch_busy,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_discard_cnt,
`endif
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HAVE = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_buf;
  logic        discard;
  logic        drop_evt;
  logic        advance_evt;

  // Handshake: a request transfers on a cycle where imem_req && imem_ready;
  // the single response is the next cycle with imem_rvalid while in WAIT.
  assign drop_evt    = (state == WAIT) && imem_rvalid && (discard || PCSrcE);
  assign advance_evt = (state == HAVE) && !PCSrcE && !StallF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr_buf <= NOP_INSTR;
      discard   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PCSrcE) pc <= PCTargetE;
          state <= REQ;
        end
        REQ: begin
          if (PCSrcE) begin
            pc <= PCTargetE;
            // A request accepted in the redirect cycle is for the old PC, so its response must be dropped.
            if (imem_ready) begin
              state   <= WAIT;
              discard <= 1'b1;
            end
          end else if (imem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (PCSrcE) pc <= PCTargetE;
          if (imem_rvalid) begin
            if (drop_evt) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              instr_buf <= imem_rdata;
              state     <= HAVE;
            end
          end else if (PCSrcE) begin
            discard <= 1'b1;
          end
        end
        HAVE: begin
          if (PCSrcE) begin
            pc        <= PCTargetE;
            instr_buf <= NOP_INSTR;
            state     <= REQ;
          end else if (!StallF) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt   <= 32'd0;
      perf_discard_cnt <= 16'd0;
    end else begin
      if (advance_evt && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop_evt && (perf_discard_cnt != 16'hFFFF))
        perf_discard_cnt <= perf_discard_cnt + 16'd1;
    end
  end
`endif

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign PCF        = pc;
  assign PCplus4F   = pc + 32'd4;
  assign validF     = (state == HAVE);
  assign fetch_busy = ~validF;
  assign instrF     = validF ? instr_buf : NOP_INSTR;
  assign state_dbg  = state;

endmodule
